// File: rtl/adder_result_checker.sv
// Compares a reference adder against a DUV adder over a run of NUM_VECTORS vectors.
// Latency: counters and first-error capture update on the edge that accepts a vector; done follows the last vector by one edge.
// Backpressure: none; valid=0 cycles stall the run indefinitely, start is ignored while a run is active.
module adder_result_checker #(
    parameter int          N           = 16,
    parameter int          TYPE        = 1,
    parameter int unsigned NUM_VECTORS = 30000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          valid,
    input  logic          cin,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic [N-1:0]  s_ref,
    input  logic [N-1:0]  s_duv,
    input  logic          cout_ref,
    input  logic          cout_duv,
    input  logic          prop_ref,
    input  logic          prop_duv,
    input  logic          gen_ref,
    input  logic          gen_duv,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [31:0]   vec_count,
    output logic [31:0]   err_count,
    output logic          first_err_valid,
    output logic [31:0]   first_err_idx,
    output logic          first_err_cin,
    output logic [N-1:0]  first_err_a,
    output logic [N-1:0]  first_err_b,
    output logic [3:0]    first_err_mask
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] mask;
    logic       accept;
    logic       launch;
    logic       last_vec;

    // Per-vector mismatch flags ({gen,prop,cout,s}) and run-control decodes.
    always_comb begin
        mask     = 4'b0000;
        mask[0]  = (s_ref != s_duv);
        mask[1]  = (cout_ref != cout_duv);
        if (TYPE == 1) begin
            mask[2] = (prop_ref != prop_duv);
            mask[3] = (gen_ref != gen_duv);
        end
        accept   = (state == RUN) && valid;
        launch   = (state != RUN) && start;
        last_vec = (vec_count == 32'(NUM_VECTORS - 1));
    end

    // Next-state logic: start launches a run from IDLE or DONE, the final accepted vector ends it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (valid && last_vec) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Run counters and first-failure capture; cleared on launch, frozen outside RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_count       <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_cin   <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_mask  <= '0;
        end else if (launch) begin
            vec_count       <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_cin   <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_mask  <= '0;
        end else if (accept) begin
            vec_count <= vec_count + 32'd1;
            if (mask != 4'b0000) begin
                if (err_count != 32'hFFFF_FFFF) err_count <= err_count + 32'd1;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_idx   <= vec_count;
                    first_err_cin   <= cin;
                    first_err_a     <= a;
                    first_err_b     <= b;
                    first_err_mask  <= mask;
                end
            end
        end
    end

    // Status flags decode directly from the state and the error counter.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
        pass = (state == DONE) && (err_count == 32'd0);
    end

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: TYPE=0 and TYPE=1 instances share one stimulus stream.
// A run-level model predicts every output and is compared on each falling edge.
// Directed scenarios add literal expectations at the points of interest.
module tb_adder_result_checker;

    localparam int N  = 16;
    localparam int NV = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, valid, cin;
    logic [N-1:0]  a, b, s_ref, s_duv;
    logic          cout_ref, cout_duv, prop_ref, prop_duv, gen_ref, gen_duv;

    logic          busy0, done0, pass0, fev0, fcin0;
    logic [31:0]   vc0, ec0, fidx0;
    logic [N-1:0]  fa0, fb0;
    logic [3:0]    fmask0;
    logic          busy1, done1, pass1, fev1, fcin1;
    logic [31:0]   vc1, ec1, fidx1;
    logic [N-1:0]  fa1, fb1;
    logic [3:0]    fmask1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adder_result_checker #(.N(N), .TYPE(0), .NUM_VECTORS(NV)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .valid(valid), .cin(cin), .a(a), .b(b),
        .s_ref(s_ref), .s_duv(s_duv), .cout_ref(cout_ref), .cout_duv(cout_duv),
        .prop_ref(prop_ref), .prop_duv(prop_duv), .gen_ref(gen_ref), .gen_duv(gen_duv),
        .busy(busy0), .done(done0), .pass(pass0), .vec_count(vc0), .err_count(ec0),
        .first_err_valid(fev0), .first_err_idx(fidx0), .first_err_cin(fcin0),
        .first_err_a(fa0), .first_err_b(fb0), .first_err_mask(fmask0)
    );

    adder_result_checker #(.N(N), .TYPE(1), .NUM_VECTORS(NV)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .valid(valid), .cin(cin), .a(a), .b(b),
        .s_ref(s_ref), .s_duv(s_duv), .cout_ref(cout_ref), .cout_duv(cout_duv),
        .prop_ref(prop_ref), .prop_duv(prop_duv), .gen_ref(gen_ref), .gen_duv(gen_duv),
        .busy(busy1), .done(done1), .pass(pass1), .vec_count(vc1), .err_count(ec1),
        .first_err_valid(fev1), .first_err_idx(fidx1), .first_err_cin(fcin1),
        .first_err_a(fa1), .first_err_b(fb1), .first_err_mask(fmask1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Run-level model, one slot per instance (index = TYPE).
    bit          m_run [2];
    bit          m_fin [2];
    logic [31:0] m_vc  [2];
    logic [31:0] m_ec  [2];
    bit          m_fev [2];
    logic [31:0] m_idx [2];
    logic        m_cin [2];
    logic [N-1:0] m_a  [2];
    logic [N-1:0] m_b  [2];
    logic [3:0]  m_mask[2];

    always @(posedge clk or negedge rst_n) begin
        for (int t = 0; t < 2; t++) begin
            logic [3:0] mk;
            mk = {(t == 1) && (gen_ref !== gen_duv), (t == 1) && (prop_ref !== prop_duv),
                  cout_ref !== cout_duv, s_ref !== s_duv};
            if (!rst_n) begin
                m_run[t] = 0; m_fin[t] = 0; m_vc[t] = 0; m_ec[t] = 0; m_fev[t] = 0;
                m_idx[t] = 0; m_cin[t] = 0; m_a[t] = 0; m_b[t] = 0; m_mask[t] = 0;
            end else if (!m_run[t] && start) begin
                m_run[t] = 1; m_fin[t] = 0; m_vc[t] = 0; m_ec[t] = 0; m_fev[t] = 0;
                m_idx[t] = 0; m_cin[t] = 0; m_a[t] = 0; m_b[t] = 0; m_mask[t] = 0;
            end else if (m_run[t] && valid) begin
                if (mk != 0) begin
                    if (m_ec[t] != 32'hFFFF_FFFF) m_ec[t] = m_ec[t] + 1;
                    if (!m_fev[t]) begin
                        m_fev[t] = 1; m_idx[t] = m_vc[t]; m_cin[t] = cin;
                        m_a[t] = a; m_b[t] = b; m_mask[t] = mk;
                    end
                end
                m_vc[t] = m_vc[t] + 1;
                if (m_vc[t] == NV) begin
                    m_run[t] = 0; m_fin[t] = 1;
                end
            end
        end
    end

    task automatic cmp(input int t, input logic bz, dn, ps, input logic [31:0] vc, ec,
                       input logic fev, input logic [31:0] fidx, input logic fcin,
                       input logic [N-1:0] fa, fb, input logic [3:0] fm);
        chk($sformatf("t%0d busy", t), bz, m_run[t]);
        chk($sformatf("t%0d done", t), dn, m_fin[t]);
        chk($sformatf("t%0d pass", t), ps, m_fin[t] && (m_ec[t] == 0));
        chk($sformatf("t%0d vec_count", t), vc, m_vc[t]);
        chk($sformatf("t%0d err_count", t), ec, m_ec[t]);
        chk($sformatf("t%0d first_err_valid", t), fev, m_fev[t]);
        chk($sformatf("t%0d first_err_idx", t), fidx, m_idx[t]);
        chk($sformatf("t%0d first_err_cin", t), fcin, m_cin[t]);
        chk($sformatf("t%0d first_err_a", t), fa, m_a[t]);
        chk($sformatf("t%0d first_err_b", t), fb, m_b[t]);
        chk($sformatf("t%0d first_err_mask", t), fm, m_mask[t]);
    endtask

    // Continuous comparison of both instances against the model.
    always @(negedge clk) begin
        cmp(0, busy0, done0, pass0, vc0, ec0, fev0, fidx0, fcin0, fa0, fb0, fmask0);
        cmp(1, busy1, done1, pass1, vc1, ec1, fev1, fidx1, fcin1, fa1, fb1, fmask1);
    end

    // One cycle of stimulus; flip selects which DUV result bits disagree ({gen,prop,cout,s}).
    task automatic step(input logic st, input logic v, input logic [3:0] flip,
                        input logic [N-1:0] av, input logic [N-1:0] bv, input logic ci);
        logic [N:0] sum;
        sum      = {1'b0, av} + {1'b0, bv} + {{N{1'b0}}, ci};
        start    = st;
        valid    = v;
        cin      = ci;
        a        = av;
        b        = bv;
        s_ref    = sum[N-1:0];
        s_duv    = sum[N-1:0] ^ {{(N-1){1'b0}}, flip[0]};
        cout_ref = sum[N];
        cout_duv = sum[N] ^ flip[1];
        prop_ref = &(av ^ bv);
        prop_duv = prop_ref ^ flip[2];
        gen_ref  = sum[N];
        gen_duv  = sum[N] ^ flip[3];
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        step(0, 0, 4'h0, 16'h0, 16'h0, 0);
        step(0, 0, 4'h0, 16'h0, 16'h0, 0);
        chk("reset busy", busy1, 1'b0);
        chk("reset vec_count", vc1, 32'd0);
        rst_n = 1'b1;

        // Clean run, with a valid pulse in IDLE that must be ignored.
        step(0, 1, 4'h0, 16'h1111, 16'h2222, 0);
        chk("idle valid ignored", vc1, 32'd0);
        step(1, 0, 4'h0, 16'h0, 16'h0, 0);
        chk("busy after start", busy1, 1'b1);
        step(0, 1, 4'h0, 16'h0001, 16'h0002, 0);
        step(0, 1, 4'h0, 16'hFFFF, 16'h0001, 0);
        step(0, 1, 4'h0, 16'h8000, 16'h8000, 1);
        chk("not done before last", done1, 1'b0);
        step(0, 1, 4'h0, 16'h00FF, 16'hFF00, 1);
        chk("clean done", done1, 1'b1);
        chk("clean pass", pass1, 1'b1);
        chk("clean vec_count", vc1, 32'd4);
        chk("clean err_count", ec1, 32'd0);
        chk("clean first_err_valid", fev1, 1'b0);

        // Sum error on vector 2, carry error on vector 3.
        step(1, 0, 4'h0, 16'h0, 16'h0, 0);
        step(0, 1, 4'h0, 16'h0003, 16'h0004, 0);
        step(0, 1, 4'h0, 16'h0010, 16'h0020, 1);
        step(0, 1, 4'h1, 16'h1234, 16'h4321, 1);
        step(0, 1, 4'h2, 16'hF000, 16'h1000, 0);
        chk("err err_count", ec1, 32'd2);
        chk("err first_idx", fidx1, 32'd2);
        chk("err first_mask", fmask1, 4'b0001);
        chk("err first_a", fa1, 16'h1234);
        chk("err first_cin", fcin1, 1'b1);
        chk("err pass", pass1, 1'b0);
        chk("err done", done1, 1'b1);

        // Only prop disagrees: visible to TYPE=1 only.
        step(1, 0, 4'h0, 16'h0, 16'h0, 0);
        step(0, 1, 4'h4, 16'hAAAA, 16'h5555, 0);
        step(0, 1, 4'h0, 16'h0001, 16'h0001, 0);
        step(0, 1, 4'h0, 16'h0002, 16'h0002, 0);
        step(0, 1, 4'h0, 16'h0003, 16'h0003, 0);
        chk("type0 err_count", ec0, 32'd0);
        chk("type0 pass", pass0, 1'b1);
        chk("type1 err_count", ec1, 32'd1);
        chk("type1 first_mask", fmask1, 4'b0100);

        // Reset mid-run, then a full run.
        step(1, 0, 4'h0, 16'h0, 16'h0, 0);
        step(0, 1, 4'h1, 16'h0101, 16'h0202, 0);
        step(0, 1, 4'h0, 16'h0303, 16'h0404, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst busy", busy1, 1'b0);
        chk("midrst vec_count", vc1, 32'd0);
        chk("midrst err_count", ec1, 32'd0);
        chk("midrst first_err_valid", fev1, 1'b0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        step(1, 0, 4'h0, 16'h0, 16'h0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 4'h0, 16'(i * 7), 16'(i * 13), 1'(i));
        chk("post-reset vec_count", vc1, 32'd4);
        chk("post-reset done", done1, 1'b1);

        // Valid in DONE ignored, start in RUN ignored, gaps stall, start in DONE relaunches.
        step(0, 1, 4'h1, 16'h7777, 16'h1111, 0);
        chk("done valid ignored", vc1, 32'd4);
        chk("done valid err_count", ec1, 32'd0);
        step(1, 1, 4'h1, 16'h7777, 16'h1111, 0);
        chk("relaunch vec_count", vc1, 32'd0);
        chk("relaunch busy", busy1, 1'b1);
        step(0, 1, 4'h0, 16'h0001, 16'h0001, 0);
        step(1, 1, 4'h0, 16'h0002, 16'h0002, 0);
        chk("start in run ignored", vc1, 32'd2);
        step(0, 0, 4'h0, 16'h0, 16'h0, 0);
        step(0, 0, 4'h0, 16'h0, 16'h0, 0);
        chk("gap stall", vc1, 32'd2);
        step(0, 1, 4'h2, 16'h0003, 16'h0003, 1);
        step(0, 1, 4'h0, 16'h0004, 16'h0004, 0);
        chk("final done", done1, 1'b1);
        chk("final first_idx", fidx1, 32'd2);
        chk("final first_mask", fmask1, 4'b0010);
        step(0, 0, 4'h0, 16'h0, 16'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_result_checker.md
ADDER_RESULT_CHECKER -- requirements
Module: adder_result_checker

Interface
REQ-001 The block SHALL have parameter N, default 16, adder operand width.
REQ-002 The block SHALL have parameter TYPE, default 1; 0 = compare s/cout only (csa, cra, a1csa); 1 = also compare prop/gen (cla, a1csah).
REQ-003 The block SHALL have parameter NUM_VECTORS, default 30000, vectors per run (1 to 2^32-1).
REQ-004 The block SHALL have ports: clk  in  1  rising-edge clock, sole clock domain.
REQ-005 The block SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-006 The block SHALL have ports: start  in  1  begin a run (level-sampled, one-cycle pulse expected).
REQ-007 The block SHALL have ports: valid  in  1  current vector/result pair is valid this cycle.
REQ-008 The block SHALL have ports: cin  in  1;  a, b  in  N  each  the stimulus applied to both adders.
REQ-009 The block SHALL have ports: s_ref, s_duv  in  N  each; cout_ref, cout_duv, prop_ref, prop_duv, gen_ref, gen_duv  in  1  each  reference and DUV results.
REQ-010 The block SHALL have ports: busy  out  1  run in progress; done  out  1  run finished; pass  out  1  run finished with zero mismatches.
REQ-011 The block SHALL have ports: vec_count, err_count  out  32 each  accepted vectors and mismatching vectors in current/last run.
REQ-012 The block SHALL have ports: first_err_valid  out  1; first_err_idx  out  32; first_err_cin  out  1; first_err_a, first_err_b  out  N each; first_err_mask  out  4  ({gen,prop,cout,s} mismatch flags) of the first failing vector.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-014 IDLE or DONE with start=1 SHALL move to RUN next edge, clearing vec_count, err_count, first_err_* (all zero) in that same edge.
REQ-015 start while in RUN SHALL be ignored.
REQ-016 In RUN, a cycle with valid=1 SHALL be an accepted vector; valid in IDLE/DONE SHALL be ignored (no counter change).
REQ-017 Each accepted vector SHALL produce mask bits: s = (s_ref!=s_duv), cout = (cout_ref!=cout_duv), prop/gen likewise when TYPE=1, forced 0 when TYPE=0.
REQ-018 An accepted vector SHALL increment vec_count by 1 on the same clock edge; if mask!=0 err_count SHALL increment by 1, saturating at 2^32-1.
REQ-019 On the first accepted vector with mask!=0 in a run, first_err_valid SHALL set to 1 and first_err_idx (=vec_count before increment, 0-based), cin, a, b, mask SHALL be captured; later errors SHALL NOT overwrite them.
REQ-020 When the accepted vector brings vec_count to NUM_VECTORS, state SHALL go to DONE on that same edge; done visible the following cycle (latency one edge after last vector).
REQ-021 In DONE, pass SHALL equal (err_count==0); pass SHALL be 0 in IDLE and RUN.
REQ-022 In DONE all counters and first_err_* SHALL hold until the next start.
REQ-023 Gaps (valid=0) in RUN SHALL stall the run without timeout.

Reset
REQ-024 rst_n=0 SHALL asynchronously force state IDLE and every output to 0, including mid-run; after release the block SHALL wait for start.

Verification
REQ-025 NUM_VECTORS=4, start then 4 valid vectors with s_ref=s_duv, all flags equal -> done=1, pass=1, vec_count=4, err_count=0, first_err_valid=0.
REQ-026 NUM_VECTORS=4, vector 2 has s_duv=s_ref^16'h0001, vector 3 has cout_duv inverted -> err_count=2, first_err_idx=2, first_err_mask=4'b0001, pass=0.
REQ-027 TYPE=0 vs TYPE=1, one vector with only prop_duv differing -> TYPE=0 err_count=0; TYPE=1 err_count=1, mask=4'b0100.
REQ-028 rst_n pulsed low after 2 of 4 vectors -> all outputs 0 immediately; following start and 4 vectors -> vec_count=4, done=1.
REQ-029 start pulsed during RUN and valid asserted during IDLE/DONE -> no counter change, run completes at NUM_VECTORS; start in DONE clears counters and re-enters RUN.
